// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan decoder: active-low glyph codes
// (bit0 = segment a ... bit6 = segment g) and the dwell-tracking state type.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HELD
  } state_t;

endpackage

// File: rtl/seg_to_hex.sv
// Combinational decode of an active-low segment pattern back to a hex nibble.
// Anything that is not one of the sixteen glyphs decodes to 0 with invalid set.
module seg_to_hex
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       invalid
);

  always_comb begin
    nibble  = 4'h0;
    invalid = 1'b0;
    case (seg)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Passive monitor of a multiplexed active-low 7-segment bus; captures one
// digit per settled anode dwell and publishes a frame once all digits are seen.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [6:0]              seg,
  output logic [4*NUM_DIGITS-1:0] hex_value,
  output logic [NUM_DIGITS-1:0]   digit_invalid,
  output logic                    frame_valid,
  output logic                    err_overlap
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  state_t                  state_q, state_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic [4*NUM_DIGITS-1:0] slot_val_q, slot_val_d;
  logic [NUM_DIGITS-1:0]   slot_inv_q, slot_inv_d;
  logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
  logic [NUM_DIGITS-1:0]   inv_q, inv_d;
  logic                    fv_q, fv_d;

  logic [3:0] dec_nibble;
  logic       dec_invalid;
  logic       pins_chg;
  logic       an_ok;
  logic       capture;

  function automatic logic one_cold(input logic [NUM_DIGITS-1:0] v);
    return $countones(~v) == 1;
  endfunction

  seg_to_hex u_dec (
    .seg     (seg_q),
    .nibble  (dec_nibble),
    .invalid (dec_invalid)
  );

  always_comb begin
    an_d       = an;
    seg_d      = seg;
    pins_chg   = (an != an_q) || (seg != seg_q);
    an_ok      = one_cold(an);
    cnt_d      = cnt_q;
    state_d    = state_q;
    mask_d     = mask_q;
    slot_val_d = slot_val_q;
    slot_inv_d = slot_inv_q;
    hex_d      = hex_q;
    inv_d      = inv_q;
    fv_d       = 1'b0;

    if (pins_chg || !an_ok) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(STABLE_CYCLES)) begin
      cnt_d = cnt_q + 1'b1;
    end

    // Fires on the edge that completes STABLE_CYCLES unchanged samples.
    capture = (state_q == SETTLE) && !pins_chg && (cnt_q == CW'(STABLE_CYCLES - 1));

    if (!an_ok) begin
      state_d = IDLE;
    end else if (pins_chg) begin
      state_d = SETTLE;
    end else if (capture || state_q == HELD) begin
      state_d = HELD;
    end else begin
      state_d = SETTLE;
    end

    if (&mask_q) begin
      hex_d  = slot_val_q;
      inv_d  = slot_inv_q;
      fv_d   = 1'b1;
      mask_d = '0;
    end

    if (capture) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (!an_q[i]) begin
          slot_val_d[4*i +: 4] = dec_nibble;
          slot_inv_d[i]        = dec_invalid;
          mask_d[i]            = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_q       <= '1;
      seg_q      <= SEG_BLANK;
      cnt_q      <= '0;
      state_q    <= IDLE;
      mask_q     <= '0;
      slot_val_q <= '0;
      slot_inv_q <= '0;
      hex_q      <= '0;
      inv_q      <= '0;
      fv_q       <= 1'b0;
    end else begin
      an_q       <= an_d;
      seg_q      <= seg_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      mask_q     <= mask_d;
      slot_val_q <= slot_val_d;
      slot_inv_q <= slot_inv_d;
      hex_q      <= hex_d;
      inv_q      <= inv_d;
      fv_q       <= fv_d;
    end
  end

  assign hex_value     = hex_q;
  assign digit_invalid = inv_q;
  assign frame_valid   = fv_q;
  assign err_overlap   = ($countones(~an_q) > 1);

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: dwell-length reference model plus directed and
// random scans, compared every cycle on the falling edge.
module tb_seg_scan_decoder;

  localparam int ND = 4;
  localparam int SC = 16;
  localparam logic [6:0] CODES [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [ND-1:0]   an = '1;
  logic [6:0]      seg = 7'h7F;
  logic [4*ND-1:0] hex_value;
  logic [ND-1:0]   digit_invalid;
  logic            frame_valid;
  logic            err_overlap;

  int n_checks = 0;
  int n_fail   = 0;
  int dut_frames = 0;
  int m_frames   = 0;

  seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .an            (an),
    .seg           (seg),
    .hex_value     (hex_value),
    .digit_invalid (digit_invalid),
    .frame_valid   (frame_valid),
    .err_overlap   (err_overlap)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a pattern is captured when it has been sampled on
  // exactly SC+1 consecutive edges with a single anode low.
  logic [ND-1:0]   prev_an;
  logic [6:0]      prev_seg;
  int              run;
  logic [ND-1:0]   m_mask;
  logic [4*ND-1:0] m_slot;
  logic [ND-1:0]   m_sinv;
  logic [4*ND-1:0] m_hex;
  logic [ND-1:0]   m_inv;
  logic            m_fv;
  logic            m_err;
  bit              started = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      prev_an = '1; prev_seg = 7'h7F; run = 0;
      m_mask = '0; m_slot = '0; m_sinv = '0;
      m_hex = '0; m_inv = '0; m_fv = 1'b0; m_err = 1'b0;
      started = 1;
    end else begin
      int zeros;
      int nib;
      bit found;
      if (m_mask == '1) begin
        m_hex = m_slot; m_inv = m_sinv; m_fv = 1'b1; m_mask = '0; m_frames++;
      end else begin
        m_fv = 1'b0;
      end
      if (an == prev_an && seg == prev_seg) run++;
      else begin run = 1; prev_an = an; prev_seg = seg; end
      zeros = $countones(~an);
      m_err = (zeros > 1);
      if (run == SC + 1 && zeros == 1) begin
        nib = 0; found = 0;
        for (int k = 0; k < 16; k++) if (CODES[k] == seg) begin nib = k; found = 1; end
        for (int d = 0; d < ND; d++) begin
          if (!an[d]) begin
            m_slot[4*d +: 4] = 4'(nib);
            m_sinv[d] = !found;
            m_mask[d] = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("hex_value", 32'(hex_value), 32'(m_hex));
      check("digit_invalid", 32'(digit_invalid), 32'(m_inv));
      check("frame_valid", 32'(frame_valid), 32'(m_fv));
      check("err_overlap", 32'(err_overlap), 32'(m_err));
      if (frame_valid) dut_frames++;
    end
  end

  // Drive a dwell: digit d (0..3) low, or d < 0 for all anodes high.
  task automatic show(input int d, input logic [6:0] code, input int n);
    an = '1;
    if (d >= 0) an[d] = 1'b0;
    seg = code;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic show_raw(input logic [ND-1:0] a, input logic [6:0] code, input int n);
    an = a;
    seg = code;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int f0;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hex", 32'(hex_value), 0);
    check("rst_inv", 32'(digit_invalid), 0);
    check("rst_fv", 32'(frame_valid), 0);
    check("rst_err", 32'(err_overlap), 0);
    rst_n = 1'b1;

    // Basic scan 1,2,3,4
    f0 = dut_frames;
    show(0, 7'h79, 20); show(1, 7'h24, 20); show(2, 7'h30, 20); show(3, 7'h19, 20);
    show(-1, 7'h7F, 3);
    check("s1_frames", 32'(dut_frames - f0), 1);
    check("s1_hex", 32'(hex_value), 32'h4321);
    check("s1_model_hex", 32'(m_hex), 32'h4321);
    check("s1_inv", 32'(digit_invalid), 0);

    // Short dwell on digit 2 is ignored until a full dwell occurs
    f0 = dut_frames;
    show(0, 7'h40, 20); show(1, 7'h79, 20); show(2, 7'h24, 10); show(3, 7'h30, 20);
    check("s2_no_frame", 32'(dut_frames - f0), 0);
    show(2, 7'h24, 20);
    show(-1, 7'h7F, 3);
    check("s2_frames", 32'(dut_frames - f0), 1);
    check("s2_hex", 32'(hex_value), 32'h3210);

    // Blank glyph on digit 1
    f0 = dut_frames;
    show(0, 7'h08, 20); show(1, 7'h7F, 20); show(2, 7'h46, 20); show(3, 7'h21, 20);
    show(-1, 7'h7F, 3);
    check("s3_frames", 32'(dut_frames - f0), 1);
    check("s3_hex", 32'(hex_value), 32'hDC0A);
    check("s3_inv", 32'(digit_invalid), 32'b0010);
    check("s3_model_inv", 32'(m_inv), 32'b0010);

    // Overlapping anodes in the middle of a partial frame
    f0 = dut_frames;
    show(0, 7'h12, 20); show(1, 7'h02, 20);
    show_raw(4'b0011, 7'h78, 5);
    check("s4_err", 32'(err_overlap), 1);
    show_raw(4'b0011, 7'h78, 25);
    check("s4_no_frame", 32'(dut_frames - f0), 0);
    show(2, 7'h00, 20); show(3, 7'h10, 20);
    show(-1, 7'h7F, 3);
    check("s4_err_clear", 32'(err_overlap), 0);
    check("s4_frames", 32'(dut_frames - f0), 1);
    check("s4_hex", 32'(hex_value), 32'h9865);

    // Reset after three captures discards the partial frame
    show(0, 7'h79, 20); show(1, 7'h79, 20); show(2, 7'h79, 20);
    rst_n = 1'b0;
    show(-1, 7'h7F, 1);
    rst_n = 1'b1;
    check("s5_rst_hex", 32'(hex_value), 0);
    f0 = dut_frames;
    show(0, 7'h06, 20); show(1, 7'h0E, 20); show(2, 7'h40, 20);
    check("s5_no_partial", 32'(dut_frames - f0), 0);
    show(3, 7'h00, 20);
    show(-1, 7'h7F, 3);
    check("s5_frames", 32'(dut_frames - f0), 1);
    check("s5_hex", 32'(hex_value), 32'h80FE);

    // Digit 0 overwritten before the frame completes
    f0 = dut_frames;
    show(0, 7'h12, 20); show(0, 7'h10, 20);
    show(1, 7'h79, 20); show(2, 7'h24, 20); show(3, 7'h30, 20);
    show(-1, 7'h7F, 3);
    check("s6_frames", 32'(dut_frames - f0), 1);
    check("s6_hex", 32'(hex_value), 32'h3219);

    // Capture boundary: SC samples is too short, SC+1 is enough
    f0 = dut_frames;
    show(1, 7'h19, 20); show(2, 7'h19, 20); show(3, 7'h19, 20);
    show(0, 7'h06, SC);
    show(-1, 7'h7F, 3);
    check("s7_short", 32'(dut_frames - f0), 0);
    show(0, 7'h06, SC + 1);
    show(-1, 7'h7F, 3);
    check("s7_exact", 32'(dut_frames - f0), 1);
    check("s7_hex", 32'(hex_value), 32'h444E);

    // Random scans against the model
    for (int r = 0; r < 80; r++) begin
      int sel;
      logic [6:0] code;
      logic [ND-1:0] a;
      sel = $urandom_range(0, 9);
      code = ($urandom_range(0, 4) == 0) ? 7'($urandom) : CODES[$urandom_range(0, 15)];
      if (sel < 7) begin
        a = '1;
        a[sel % ND] = 1'b0;
      end else if (sel == 7) begin
        a = '1;
      end else begin
        a = 4'($urandom);
        if ($countones(~a) < 2) a = 4'b1001;
      end
      show_raw(a, code, $urandom_range(1, 24));
    end
    show(-1, 7'h7F, 40);
    check("rand_frame_count", 32'(dut_frames), 32'(m_frames));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
